stream_width_adapter: RTL and testbench

Parametrised AXI-Stream-style width converter between a leaf_interface user port and an HLS operator port. It is the successor of read_queue, which only upsizes. It supports three modes, selected from the parameters:
- upsize (OUT_WIDTH = N*IN_WIDTH)
- downsize (IN_WIDTH = N*OUT_WIDTH)
- pass-through register (equal widths)
It adds a partial-word flush, a valid-beat count, and ap_start gating. It is instantiated per port inside page wrappers, in the clk domain of the owning leaf.

---
 rtl/stream_adapter_pkg.sv | 42 ++++
 rtl/stream_out_slot.sv | 59 +++++
 rtl/stream_width_adapter.sv | 176 +++++++++++++++++
 tb/tb_stream_width_adapter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_adapter_pkg.sv
// Shared definitions for the stream width adapter.
//
// Contents:
//   mode_e        - conversion mode selected from the two payload widths
//   calc_mode     - picks pass / upsize / downsize from (in_width, out_width)
//   calc_ratio    - larger width divided by smaller width
//   calc_cnt_bits - width of the beat / slice counter, never below 1
package stream_adapter_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2
  } mode_e;

  function automatic mode_e calc_mode(input int unsigned in_width,
                                      input int unsigned out_width);
    if (in_width == out_width) begin
      return MODE_PASS;
    end else if (out_width > in_width) begin
      return MODE_UP;
    end
    return MODE_DOWN;
  endfunction

  function automatic int unsigned calc_ratio(input int unsigned in_width,
                                             input int unsigned out_width);
    if (in_width > out_width) begin
      return in_width / out_width;
    end
    return out_width / in_width;
  endfunction

  // A ratio of 1 or 2 still needs one counter bit.
  function automatic int unsigned calc_cnt_bits(input int unsigned ratio);
    if (ratio < 2) begin
      return 1;
    end
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/stream_out_slot.sv
// One-entry output register with valid/ready handshake.
//
// It holds a data word plus a beats field. The owner asserts load only when
// free is high. The owner also decides when the entry retires by driving pop.
// In pass and upsize mode pop is the downstream ready. In downsize mode pop is
// asserted only on the last slice.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   load        - write load_data/load_beats into the slot
//   load_data   - word to store
//   load_beats  - beats field to store with the word
//   pop         - the stored entry is consumed this cycle
//   free        - slot can accept a load this cycle (!vld | pop)
//   vld         - slot holds a valid entry
//   data, beats - stored word and beats field; held while not loaded
module stream_out_slot #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned BeatsWidth = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DataWidth-1:0]  load_data,
  input  logic [BeatsWidth-1:0] load_beats,
  input  logic                  pop,
  output logic                  free,
  output logic                  vld,
  output logic [DataWidth-1:0]  data,
  output logic [BeatsWidth-1:0] beats
);

  logic                  vld_q;
  logic [DataWidth-1:0]  data_q;
  logic [BeatsWidth-1:0] beats_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      beats_q <= '0;
    end else if (load) begin
      vld_q   <= 1'b1;
      data_q  <= load_data;
      beats_q <= load_beats;
    end else if (pop) begin
      vld_q <= 1'b0;
    end
  end

  assign free  = ~vld_q | pop;
  assign vld   = vld_q;
  assign data  = data_q;
  assign beats = beats_q;

  // A load into an occupied slot that is not draining would drop a word.
  load_needs_free : assert property (@(posedge clk) disable iff (reset) load |-> free);

endmodule

// File: rtl/stream_width_adapter.sv
// AXI-Stream-style width converter between a leaf_interface user port and an
// HLS operator port. The mode follows from the parameters:
//   OUT_WIDTH = N*IN_WIDTH  -> upsize (LSB-first accumulation, partial flush)
//   IN_WIDTH  = N*OUT_WIDTH -> downsize (low slice first)
//   equal widths            -> one-entry pass-through register
// Upstream is held off until ap_start has been seen once after reset.
//
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   ap_start      - start strobe, latched sticky
//   din, vld_in   - upstream payload and valid
//   rdy_upward    - ready to upstream
//   dout, vld_out - downstream payload and valid
//   rdy_downward  - downstream ready
//   flush         - upsize only: emit the partial word (level sensitive)
//   dout_beats    - valid IN beats in dout (upsize), RATIO (downsize), 1 (pass)
module stream_width_adapter
  import stream_adapter_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ap_start,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 vld_in,
  output logic                 rdy_upward,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 vld_out,
  input  logic                 rdy_downward,
  input  logic                 flush,
  output logic [calc_cnt_bits(calc_ratio(IN_WIDTH, OUT_WIDTH)):0] dout_beats
);

  localparam mode_e       MODE        = calc_mode(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned RATIO       = calc_ratio(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned CNT_BITS    = calc_cnt_bits(RATIO);
  localparam int unsigned BEATS_WIDTH = CNT_BITS + 1;
  localparam int unsigned SLOT_WIDTH  = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int unsigned SMALL_WIDTH = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;

  if (SLOT_WIDTH % SMALL_WIDTH != 0) begin : g_bad_ratio
    $error("stream_width_adapter: larger width must be a multiple of the smaller width");
  end

  // Sticky start flag
  logic started_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started_q <= 1'b0;
    end else if (ap_start) begin
      started_q <= 1'b1;
    end
  end

  // Output slot, shared by every mode
  logic                   slot_load;
  logic [SLOT_WIDTH-1:0]  slot_data_in;
  logic [BEATS_WIDTH-1:0] slot_beats_in;
  logic                   slot_pop;
  logic                   slot_free;
  logic                   slot_vld;
  logic [SLOT_WIDTH-1:0]  slot_data;
  logic [BEATS_WIDTH-1:0] slot_beats;

  stream_out_slot #(
    .DataWidth (SLOT_WIDTH),
    .BeatsWidth(BEATS_WIDTH)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (slot_load),
    .load_data (slot_data_in),
    .load_beats(slot_beats_in),
    .pop       (slot_pop),
    .free      (slot_free),
    .vld       (slot_vld),
    .data      (slot_data),
    .beats     (slot_beats)
  );

  assign vld_out    = slot_vld;
  assign dout_beats = slot_beats;

  if (MODE == MODE_PASS) begin : g_pass

    logic unused_flush;
    assign unused_flush = flush;

    assign rdy_upward    = started_q & slot_free;
    assign slot_load     = vld_in & rdy_upward;
    assign slot_data_in  = din;
    assign slot_beats_in = BEATS_WIDTH'(1);
    assign slot_pop      = rdy_downward;
    assign dout          = slot_data;

  end else if (MODE == MODE_UP) begin : g_up

    logic [CNT_BITS-1:0]  count_q;
    logic [OUT_WIDTH-1:0] acc_q;
    logic [OUT_WIDTH-1:0] word;
    logic                 last_beat;
    logic                 beat_xfer;
    logic                 do_flush;

    assign last_beat = (count_q == CNT_BITS'(RATIO - 1));
    // The last beat goes straight into the slot, so it may only be taken
    // when the slot can accept a word this cycle.
    assign rdy_upward = started_q & ~flush & (~last_beat | slot_free);
    assign beat_xfer  = vld_in & rdy_upward;
    assign do_flush   = flush & (count_q != '0) & slot_free;

    // Accumulator with the incoming beat merged at its lane
    always_comb begin
      word = acc_q;
      word[count_q*IN_WIDTH +: IN_WIDTH] = din;
    end

    // beat_xfer and do_flush are exclusive because flush drops rdy_upward.
    // The accumulator is cleared whenever a word leaves, so a flushed word
    // already carries zeros in its unused upper lanes.
    assign slot_load     = (beat_xfer & last_beat) | do_flush;
    assign slot_data_in  = do_flush ? acc_q : word;
    assign slot_beats_in = do_flush ? {1'b0, count_q} : BEATS_WIDTH'(RATIO);
    assign slot_pop      = rdy_downward;
    assign dout          = slot_data;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q <= '0;
        acc_q   <= '0;
      end else if (beat_xfer) begin
        if (last_beat) begin
          count_q <= '0;
          acc_q   <= '0;
        end else begin
          count_q <= count_q + CNT_BITS'(1);
          acc_q   <= word;
        end
      end else if (do_flush) begin
        count_q <= '0;
        acc_q   <= '0;
      end
    end

  end else begin : g_down

    logic [CNT_BITS-1:0] idx_q;
    logic                last_slice;

    logic unused_flush;
    assign unused_flush = flush;

    assign last_slice = (idx_q == CNT_BITS'(RATIO - 1));
    // The slot acts as the holding register and retires on the last slice,
    // which lets a new word load in the same cycle without a bubble.
    assign slot_pop      = rdy_downward & last_slice;
    assign rdy_upward    = started_q & slot_free;
    assign slot_load     = vld_in & rdy_upward;
    assign slot_data_in  = din;
    assign slot_beats_in = BEATS_WIDTH'(RATIO);
    assign dout          = slot_data[idx_q*OUT_WIDTH +: OUT_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        idx_q <= '0;
      end else if (slot_vld & rdy_downward) begin
        idx_q <= last_slice ? '0 : idx_q + CNT_BITS'(1);
      end
    end

  end

endmodule

// File: tb/tb_stream_width_adapter.sv
// Bench for stream_width_adapter: upsize 32->128, downsize 128->32 and pass 32->32
// instances, driven from cycle tables of {inputs, expected outputs}.
module tb_stream_width_adapter;

  logic clk = 1'b0;
  logic reset;
  logic ap_start;

  always #5 clk = ~clk;

  // Upsize 32 -> 128
  logic         up_vld, up_rdy, up_flush, up_rdy_dn, up_vld_out;
  logic [31:0]  up_din;
  logic [127:0] up_dout;
  logic [2:0]   up_beats;

  // Downsize 128 -> 32
  logic         dn_vld, dn_rdy, dn_flush, dn_rdy_dn, dn_vld_out;
  logic [127:0] dn_din;
  logic [31:0]  dn_dout;
  logic [2:0]   dn_beats;

  // Pass 32 -> 32
  logic         ps_vld, ps_rdy, ps_flush, ps_rdy_dn, ps_vld_out;
  logic [31:0]  ps_din;
  logic [31:0]  ps_dout;
  logic [1:0]   ps_beats;

  stream_width_adapter #(.IN_WIDTH(32), .OUT_WIDTH(128)) u_up (
    .clk(clk), .reset(reset), .ap_start(ap_start), .din(up_din), .vld_in(up_vld),
    .rdy_upward(up_rdy), .dout(up_dout), .vld_out(up_vld_out), .rdy_downward(up_rdy_dn),
    .flush(up_flush), .dout_beats(up_beats)
  );

  stream_width_adapter #(.IN_WIDTH(128), .OUT_WIDTH(32)) u_dn (
    .clk(clk), .reset(reset), .ap_start(ap_start), .din(dn_din), .vld_in(dn_vld),
    .rdy_upward(dn_rdy), .dout(dn_dout), .vld_out(dn_vld_out), .rdy_downward(dn_rdy_dn),
    .flush(dn_flush), .dout_beats(dn_beats)
  );

  stream_width_adapter #(.IN_WIDTH(32), .OUT_WIDTH(32)) u_ps (
    .clk(clk), .reset(reset), .ap_start(ap_start), .din(ps_din), .vld_in(ps_vld),
    .rdy_upward(ps_rdy), .dout(ps_dout), .vld_out(ps_vld_out), .rdy_downward(ps_rdy_dn),
    .flush(ps_flush), .dout_beats(ps_beats)
  );

  typedef struct {
    bit          vld;
    logic [31:0] din;
    bit          flush;
    bit          rdy_dn;
    bit          e_rdy;
    bit          e_vld;
    logic [127:0] e_dout;
    logic [2:0]  e_beats;
  } up_vec_t;

  typedef struct {
    bit           vld;
    logic [127:0] din;
    bit           rdy_dn;
    bit           e_rdy;
    bit           e_vld;
    logic [31:0]  e_dout;
  } dn_vec_t;

  typedef struct {
    bit          vld;
    logic [31:0] din;
    bit          rdy_dn;
    bit          e_rdy;
    bit          e_vld;
    logic [31:0] e_dout;
  } ps_vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic up_vec_t mk_up(bit vld, logic [31:0] din, bit flush, bit rdy_dn,
                                    bit e_rdy, bit e_vld, logic [127:0] e_dout,
                                    logic [2:0] e_beats);
    up_vec_t v;
    v.vld = vld; v.din = din; v.flush = flush; v.rdy_dn = rdy_dn;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dout = e_dout; v.e_beats = e_beats;
    return v;
  endfunction

  function automatic dn_vec_t mk_dn(bit vld, logic [127:0] din, bit rdy_dn,
                                    bit e_rdy, bit e_vld, logic [31:0] e_dout);
    dn_vec_t v;
    v.vld = vld; v.din = din; v.rdy_dn = rdy_dn;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dout = e_dout;
    return v;
  endfunction

  function automatic ps_vec_t mk_ps(bit vld, logic [31:0] din, bit rdy_dn,
                                    bit e_rdy, bit e_vld, logic [31:0] e_dout);
    ps_vec_t v;
    v.vld = vld; v.din = din; v.rdy_dn = rdy_dn;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dout = e_dout;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic apply_up(input up_vec_t v, input string tag);
    @(negedge clk);
    up_vld = v.vld; up_din = v.din; up_flush = v.flush; up_rdy_dn = v.rdy_dn;
    #1;
    check({tag, ".rdy_upward"}, 128'(up_rdy), 128'(v.e_rdy));
    check({tag, ".vld_out"}, 128'(up_vld_out), 128'(v.e_vld));
    if (v.e_vld) begin
      check({tag, ".dout"}, up_dout, v.e_dout);
      check({tag, ".dout_beats"}, 128'(up_beats), 128'(v.e_beats));
    end
  endtask

  task automatic apply_dn(input dn_vec_t v, input string tag);
    @(negedge clk);
    dn_vld = v.vld; dn_din = v.din; dn_rdy_dn = v.rdy_dn;
    #1;
    check({tag, ".rdy_upward"}, 128'(dn_rdy), 128'(v.e_rdy));
    check({tag, ".vld_out"}, 128'(dn_vld_out), 128'(v.e_vld));
    if (v.e_vld) begin
      check({tag, ".dout"}, 128'(dn_dout), 128'(v.e_dout));
      check({tag, ".dout_beats"}, 128'(dn_beats), 128'd4);
    end
  endtask

  task automatic apply_ps(input ps_vec_t v, input string tag);
    @(negedge clk);
    ps_vld = v.vld; ps_din = v.din; ps_rdy_dn = v.rdy_dn;
    #1;
    check({tag, ".rdy_upward"}, 128'(ps_rdy), 128'(v.e_rdy));
    check({tag, ".vld_out"}, 128'(ps_vld_out), 128'(v.e_vld));
    if (v.e_vld) begin
      check({tag, ".dout"}, 128'(ps_dout), 128'(v.e_dout));
      check({tag, ".dout_beats"}, 128'(ps_beats), 128'd1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".up.rdy"}, 128'(up_rdy), 128'd0);
    check({tag, ".up.vld"}, 128'(up_vld_out), 128'd0);
    check({tag, ".up.dout"}, up_dout, 128'd0);
    check({tag, ".up.beats"}, 128'(up_beats), 128'd0);
    check({tag, ".dn.rdy"}, 128'(dn_rdy), 128'd0);
    check({tag, ".dn.vld"}, 128'(dn_vld_out), 128'd0);
    check({tag, ".dn.dout"}, 128'(dn_dout), 128'd0);
    check({tag, ".dn.beats"}, 128'(dn_beats), 128'd0);
    check({tag, ".ps.rdy"}, 128'(ps_rdy), 128'd0);
    check({tag, ".ps.vld"}, 128'(ps_vld_out), 128'd0);
    check({tag, ".ps.dout"}, 128'(ps_dout), 128'd0);
    check({tag, ".ps.beats"}, 128'(ps_beats), 128'd0);
  endtask

  up_vec_t uv[$];
  up_vec_t ur[$];
  dn_vec_t dv[$];
  ps_vec_t pv[$];

  initial begin
    logic [127:0] w_a, w_b, w_c, w_d, w_f, w_r, dw0, dw1, tmp;

    w_a = 128'h00000004_00000003_00000002_00000001;
    w_b = 128'h00000008_00000007_00000006_00000005;
    w_c = 128'h00000014_00000013_00000012_00000011;
    w_d = 128'h00000018_00000017_00000016_00000015;
    w_f = 128'h00000000_0000000C_0000000B_0000000A;
    w_r = 128'h00000024_00000023_00000022_00000021;
    dw0 = 128'h44444444_33333333_22222222_11111111;
    dw1 = 128'h88888888_77777777_66666666_55555555;

    // Upsize: continuous valid/ready, two full words
    for (int i = 1; i <= 4; i++)
      uv.push_back(mk_up(1'b1, 32'(i), 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    uv.push_back(mk_up(1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 1'b1, w_a, 3'd4));
    for (int i = 6; i <= 8; i++)
      uv.push_back(mk_up(1'b1, 32'(i), 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    uv.push_back(mk_up(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, w_b, 3'd4));
    // Upsize: downstream stalled for 10 cycles behind the first word
    for (int i = 'h11; i <= 'h14; i++)
      uv.push_back(mk_up(1'b1, 32'(i), 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    for (int i = 'h15; i <= 'h17; i++)
      uv.push_back(mk_up(1'b1, 32'(i), 1'b0, 1'b0, 1'b1, 1'b1, w_c, 3'd4));
    for (int i = 0; i < 7; i++)
      uv.push_back(mk_up(1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 1'b1, w_c, 3'd4));
    uv.push_back(mk_up(1'b1, 32'h18, 1'b0, 1'b1, 1'b1, 1'b1, w_c, 3'd4));
    uv.push_back(mk_up(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, w_d, 3'd4));
    uv.push_back(mk_up(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    // Upsize: three beats then flush held three cycles; 0xD offered during flush
    uv.push_back(mk_up(1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    uv.push_back(mk_up(1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    uv.push_back(mk_up(1'b1, 32'hC, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    uv.push_back(mk_up(1'b1, 32'hD, 1'b1, 1'b1, 1'b0, 1'b0, '0, 3'd0));
    uv.push_back(mk_up(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, w_f, 3'd3));
    uv.push_back(mk_up(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 3'd0));
    uv.push_back(mk_up(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));

    // Upsize after a mid-word reset: a clean word
    for (int i = 'h21; i <= 'h24; i++)
      ur.push_back(mk_up(1'b1, 32'(i), 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    ur.push_back(mk_up(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, w_r, 3'd4));
    ur.push_back(mk_up(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 3'd0));

    // Downsize: ready toggles every cycle, second word follows without a bubble
    dv.push_back(mk_dn(1'b1, dw0, 1'b1, 1'b1, 1'b0, 32'h0));
    for (int s = 0; s < 8; s++) begin
      tmp = dw0 >> (32 * (s / 2));
      dv.push_back(mk_dn(1'b1, dw1, (s % 2 == 1), (s == 7), 1'b1, tmp[31:0]));
    end
    for (int s = 0; s < 8; s++) begin
      tmp = dw1 >> (32 * (s / 2));
      dv.push_back(mk_dn(1'b0, '0, (s % 2 == 1), (s == 7), 1'b1, tmp[31:0]));
    end
    dv.push_back(mk_dn(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h0));

    // Pass: one-cycle latency, backpressure, back-to-back reload
    pv.push_back(mk_ps(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0));
    pv.push_back(mk_ps(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF));
    pv.push_back(mk_ps(1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF));
    pv.push_back(mk_ps(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h12345678));
    pv.push_back(mk_ps(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));

    reset = 1'b1; ap_start = 1'b0;
    up_vld = 1'b0; up_din = '0; up_flush = 1'b0; up_rdy_dn = 1'b1;
    dn_vld = 1'b0; dn_din = '0; dn_flush = 1'b0; dn_rdy_dn = 1'b1;
    ps_vld = 1'b0; ps_din = '0; ps_flush = 1'b0; ps_rdy_dn = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");

    @(negedge clk);
    reset = 1'b0;

    // No ap_start yet: upstream must stay blocked
    up_vld = 1'b1; up_din = 32'h99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("gate[%0d].rdy_upward", i), 128'(up_rdy), 128'd0);
    end
    @(negedge clk);
    up_vld = 1'b0; ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;

    for (int i = 0; i < uv.size(); i++) apply_up(uv[i], $sformatf("up[%0d]", i));
    for (int i = 0; i < dv.size(); i++) apply_dn(dv[i], $sformatf("dn[%0d]", i));
    for (int i = 0; i < pv.size(); i++) apply_ps(pv[i], $sformatf("ps[%0d]", i));

    // Two of four beats accumulated, then an asynchronous reset between edges
    @(negedge clk);
    up_vld = 1'b1; up_din = 32'h77;
    @(negedge clk);
    up_din = 32'h66;
    @(negedge clk);
    up_vld = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    // Reset cleared the start flag as well
    #1;
    check("midreset.rdy_after_release", 128'(up_rdy), 128'd0);
    @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;

    for (int i = 0; i < ur.size(); i++) apply_up(ur[i], $sformatf("uprst[%0d]", i));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
